// File: rtl/heq_pkg.sv
// Shared state encodings and default widths for the histogram-equalisation frame sequencer.
package heq_pkg;

  localparam int HEQ_CNT_W    = 20;
  localparam int HEQ_FRAMES_W = 8;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_RUN  = 1'b1
  } fe_state_t;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_CDF  = 2'd1,
    B_DIV  = 2'd2,
    B_OUT  = 2'd3
  } be_state_t;

endpackage

// File: rtl/heq_buf_tracker.sv
// Histogram buffer pool: in-order allocation and release pointers plus a registered free count.
module heq_buf_tracker #(
  parameter int NUM_BUFS = 2,
  parameter int OFS_W    = 1,
  parameter int CF_W     = $clog2(NUM_BUFS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             alloc,
  input  logic             rel,
  output logic [CF_W-1:0]  free_cnt,
  output logic [OFS_W-1:0] alloc_ptr,
  output logic [OFS_W-1:0] rel_ptr
);

  // NUM_BUFS is a power of two, so the pointers wrap naturally; a single buffer stays at 0.
  function automatic logic [OFS_W-1:0] ptr_inc(input logic [OFS_W-1:0] p);
    return (NUM_BUFS > 1) ? p + OFS_W'(1) : '0;
  endfunction

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      free_cnt  <= CF_W'(NUM_BUFS);
      alloc_ptr <= '0;
      rel_ptr   <= '0;
    end else begin
      if (alloc) alloc_ptr <= ptr_inc(alloc_ptr);
      if (rel)   rel_ptr   <= ptr_inc(rel_ptr);
      case ({alloc, rel})
        2'b10:   free_cnt <= free_cnt - CF_W'(1);
        2'b01:   free_cnt <= free_cnt + CF_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/heq_frame_sequencer.sv
// Sequences N frames through histogram, CDF and remap engines over a small buffer pool.
// Define HEQ_OVERLAP_EN to pipeline input of later frames under CDF/remap of earlier ones.
module heq_frame_sequencer
  import heq_pkg::*;
#(
  parameter int CNT_W        = HEQ_CNT_W,
  parameter int TOTAL_PIXELS = 262144,
  parameter int NUM_BUFS     = 2,
  parameter int OFS_W        = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
  parameter int FRAMES_W     = HEQ_FRAMES_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [FRAMES_W-1:0] num_frames,
  output logic                busy,
  output logic                done,
  output logic                input_start,
  input  logic                input_done,
  output logic [OFS_W-1:0]    input_base_offset,
  output logic                cdf_start,
  input  logic                cdf_done,
  input  logic                cdf_valid,
  input  logic [CNT_W-1:0]    cdf_min_in,
  output logic [OFS_W-1:0]    cdf_base_offset,
  output logic                output_start,
  input  logic                output_done,
  output logic [CNT_W-1:0]    cdf_min_out,
  output logic [CNT_W-1:0]    divisor,
  output logic [OFS_W-1:0]    output_base_offset,
  output logic                flat_frame
);

`ifdef HEQ_OVERLAP_EN
  localparam int BUFS_EFF = NUM_BUFS;
`else
  // A one-buffer pool serialises frames and pins every offset to 0.
  localparam int BUFS_EFF = 1;
`endif
  localparam int Q_W = $clog2(BUFS_EFF + 1);
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(TOTAL_PIXELS);

  fe_state_t f_state, f_next;
  be_state_t b_state, b_next;

  logic                busy_q, done_q, flat_q;
  logic                cdf_start_q, output_start_q;
  logic [FRAMES_W-1:0] n_q, in_cnt, frames_done;
  logic [Q_W-1:0]      q_cnt, free_cnt;
  logic [CNT_W-1:0]    cdf_min_q, div_q, cdf_min_eff, div_calc;
  logic [OFS_W-1:0]    alloc_ptr, rel_ptr;
  logic                start_acc, in_go, in_fin, cdf_take, cdf_fin, out_fin, last_frame, div_flat;

  assign start_acc  = start & ~busy_q;
  // in_cnt counts completed inputs, which equals frames issued while the front end is idle.
  assign in_go      = (f_state == F_IDLE) & busy_q & (in_cnt < n_q) & (free_cnt != '0);
  assign in_fin     = (f_state == F_RUN) & input_done;
  assign cdf_take   = (b_state == B_IDLE) & (q_cnt != '0);
  assign cdf_fin    = (b_state == B_CDF) & cdf_done;
  assign out_fin    = (b_state == B_OUT) & output_done;
  assign last_frame = out_fin & ((frames_done + FRAMES_W'(1)) == n_q);

  // A valid beat in the same cycle as done is the final one and must be used.
  assign cdf_min_eff = ((b_state == B_CDF) && cdf_valid) ? cdf_min_in : cdf_min_q;
  assign div_flat    = (cdf_min_eff >= TOTAL);
  assign div_calc    = div_flat ? CNT_W'(1) : (TOTAL - cdf_min_eff);

  heq_buf_tracker #(
    .NUM_BUFS (BUFS_EFF),
    .OFS_W    (OFS_W),
    .CF_W     (Q_W)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .clr       (start_acc),
    .alloc     (in_fin),
    .rel       (out_fin),
    .free_cnt  (free_cnt),
    .alloc_ptr (alloc_ptr),
    .rel_ptr   (rel_ptr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      f_state <= F_IDLE;
      b_state <= B_IDLE;
    end else begin
      f_state <= f_next;
      b_state <= b_next;
    end
  end

  always_comb begin
    f_next = f_state;
    case (f_state)
      F_IDLE: if (in_go)      f_next = F_RUN;
      F_RUN:  if (input_done) f_next = F_IDLE;
      default:                f_next = F_IDLE;
    endcase
  end

  always_comb begin
    b_next = b_state;
    case (b_state)
      B_IDLE:  if (cdf_take)    b_next = B_CDF;
      B_CDF:   if (cdf_done)    b_next = B_DIV;
      B_DIV:                    b_next = B_OUT;
      B_OUT:   if (output_done) b_next = B_IDLE;
      default:                  b_next = B_IDLE;
    endcase
  end

  always_comb begin
    busy               = busy_q;
    done               = done_q;
    input_start        = in_go;
    cdf_start          = cdf_start_q;
    output_start       = output_start_q;
    input_base_offset  = busy_q ? alloc_ptr : '0;
    cdf_base_offset    = busy_q ? rel_ptr : '0;
    output_base_offset = busy_q ? rel_ptr : '0;
    cdf_min_out        = cdf_min_q;
    divisor            = div_q;
    flat_frame         = flat_q;
  end

  // Frames leave the ready queue in order, so a count suffices: its head is always rel_ptr.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      flat_q         <= 1'b0;
      cdf_start_q    <= 1'b0;
      output_start_q <= 1'b0;
      n_q            <= '0;
      in_cnt         <= '0;
      frames_done    <= '0;
      q_cnt          <= '0;
      cdf_min_q      <= '0;
      div_q          <= '0;
    end else begin
      done_q         <= 1'b0;
      cdf_start_q    <= cdf_take;
      output_start_q <= (b_state == B_DIV);
      if (start_acc) begin
        busy_q      <= (num_frames != '0);
        done_q      <= (num_frames == '0);
        n_q         <= num_frames;
        in_cnt      <= '0;
        frames_done <= '0;
      end
      if (in_fin)  in_cnt      <= in_cnt + FRAMES_W'(1);
      if (out_fin) frames_done <= frames_done + FRAMES_W'(1);
      if (last_frame) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
      case ({in_fin, cdf_take})
        2'b10:   q_cnt <= q_cnt + Q_W'(1);
        2'b01:   q_cnt <= q_cnt - Q_W'(1);
        default: ;
      endcase
      if ((b_state == B_CDF) && cdf_valid) cdf_min_q <= cdf_min_in;
      if (cdf_fin) begin
        div_q <= div_calc;
        if (div_flat) flat_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_heq_frame_sequencer.sv
// Directed scoreboard bench for heq_frame_sequencer with a cycle-level engine responder.
module tb_heq_frame_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, input_done, cdf_done, cdf_valid, output_done;
  logic [7:0]  num_frames;
  logic [19:0] cdf_min_in;
  logic        busy, done, input_start, cdf_start, output_start, flat_frame;
  logic [0:0]  input_base_offset, cdf_base_offset, output_base_offset;
  logic [19:0] cdf_min_out, divisor;

  int n_cmp = 0;
  int n_err = 0;

  int in_start_cyc[$], in_ofs_obs[$], cdf_ofs_obs[$], out_ofs_obs[$];
  int out_start_cyc[$], out_done_cyc[$], cdf_done_cyc[$];
  int obs_div[$], obs_min[$], exp_div[$], exp_min[$], min_plan[$];
  int done_cnt, done_cyc, coincide;
  logic done_busy;

  heq_frame_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .num_frames(num_frames),
    .busy(busy), .done(done),
    .input_start(input_start), .input_done(input_done), .input_base_offset(input_base_offset),
    .cdf_start(cdf_start), .cdf_done(cdf_done), .cdf_valid(cdf_valid),
    .cdf_min_in(cdf_min_in), .cdf_base_offset(cdf_base_offset),
    .output_start(output_start), .output_done(output_done),
    .cdf_min_out(cdf_min_out), .divisor(divisor), .output_base_offset(output_base_offset),
    .flat_frame(flat_frame)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int model_div(input int m);
    return (m >= 262144) ? 1 : 262144 - m;
  endfunction

  function automatic logic [67:0] all_outs();
    return {busy, done, input_start, input_base_offset, cdf_start, cdf_base_offset,
            output_start, cdf_min_out, divisor, output_base_offset, flat_frame};
  endfunction

  // Plays all three engines with fixed latencies; records observations, pushes expectations.
  task automatic run_frames(input int n, input int li, input int lc, input int lo,
                            input bit abort_at_out, output bit timed_out);
    int in_due, cdf_due, out_due, m;
    in_start_cyc.delete(); in_ofs_obs.delete(); cdf_ofs_obs.delete(); out_ofs_obs.delete();
    out_start_cyc.delete(); out_done_cyc.delete(); cdf_done_cyc.delete();
    obs_div.delete(); obs_min.delete(); exp_div.delete(); exp_min.delete();
    done_cnt = 0; done_cyc = -1; coincide = 0; done_busy = 1'b1; timed_out = 1'b1;
    in_due = -1; cdf_due = -1; out_due = -1; m = 1000;
    start = 1'b1; num_frames = n[7:0];
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = 1'b0; input_done = 1'b0; cdf_valid = 1'b0; cdf_done = 1'b0;
      output_done = 1'b0; cdf_min_in = '0;
      if (input_start) begin
        in_start_cyc.push_back(cyc); in_ofs_obs.push_back(int'(input_base_offset));
        in_due = cyc + li;
      end
      if (cdf_start) begin
        cdf_ofs_obs.push_back(int'(cdf_base_offset)); cdf_due = cyc + lc;
        m = (min_plan.size() > 0) ? min_plan.pop_front() : 1000;
      end
      if (output_start) begin
        out_start_cyc.push_back(cyc); obs_div.push_back(int'(divisor));
        obs_min.push_back(int'(cdf_min_out)); out_ofs_obs.push_back(int'(output_base_offset));
        out_due = cyc + lo;
        if (abort_at_out) begin timed_out = 1'b0; return; end
      end
      if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end
      if (done_cnt > 0 && cyc >= done_cyc + 3) begin timed_out = 1'b0; return; end
      if (cyc == in_due) input_done = 1'b1;
      if (cyc == cdf_due - 2) begin cdf_valid = 1'b1; cdf_min_in = 20'd5; end
      if (cyc == cdf_due - 1) begin cdf_valid = 1'b1; cdf_min_in = m[19:0]; end
      if (cyc == cdf_due) begin
        cdf_done = 1'b1; cdf_done_cyc.push_back(cyc);
        exp_min.push_back(m); exp_div.push_back(model_div(m));
      end
      if (cyc == out_due) begin output_done = 1'b1; out_done_cyc.push_back(cyc); end
      if (input_done && output_done) coincide++;
      if (cyc == 3) begin start = 1'b1; num_frames = 8'd7; end
      tick();
    end
    start = 1'b0; input_done = 1'b0; cdf_valid = 1'b0; cdf_done = 1'b0; output_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (all_outs() !== '0) begin n_err++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
    reset = 1'b0;
    tick();
    n_cmp++; if (all_outs() !== '0) begin n_err++; $display("FAIL post_reset_outs: got %h want 0", all_outs()); end
  endtask

  task automatic test_single();
    bit to;
    int e, o;
    min_plan = '{1000};
    run_frames(1, 10, 3, 4, 1'b0, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL single_timeout: got timeout want done"); end
    n_cmp++; if (in_start_cyc.size() != 1 || in_start_cyc[0] != 0) begin
      n_err++; $display("FAIL single_first_input_start: got n=%0d want one at cycle 0", in_start_cyc.size()); end
    n_cmp++; if (obs_div.size() != 1 || obs_div[0] != 261144) begin
      n_err++; $display("FAIL single_divisor: got %0d entries want 261144", obs_div.size()); end
    while (exp_div.size() > 0 && obs_div.size() > 0) begin
      e = exp_div.pop_front(); o = obs_div.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL single_sb_div: got %0d want %0d", o, e); end
      e = exp_min.pop_front(); o = obs_min.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL single_sb_min: got %0d want %0d", o, e); end
    end
    if (out_start_cyc.size() > 0 && cdf_done_cyc.size() > 0) begin
      n_cmp++; if (out_start_cyc[0] != cdf_done_cyc[0] + 2) begin
        n_err++; $display("FAIL single_ostart_lat: got %0d want %0d", out_start_cyc[0], cdf_done_cyc[0] + 2); end
    end
    if (out_done_cyc.size() > 0) begin
      n_cmp++; if (done_cyc != out_done_cyc[0] + 1) begin
        n_err++; $display("FAIL single_done_lat: got %0d want %0d", done_cyc, out_done_cyc[0] + 1); end
    end
    n_cmp++; if (done_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b want 0", done_busy); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_frames();
    logic any_start;
    start = 1'b1; num_frames = 8'd0;
    tick();
    start = 1'b0;
    n_cmp++; if ({done, busy, input_start} !== 3'b100) begin
      n_err++; $display("FAIL zero_done: got done,busy,istart=%b want 100", {done, busy, input_start}); end
    any_start = 1'b0;
    repeat (4) begin tick(); any_start |= done | input_start | cdf_start | output_start; end
    n_cmp++; if (any_start !== 1'b0) begin n_err++; $display("FAIL zero_no_starts: got %b want 0", any_start); end
  endtask

  task automatic test_ignored();
    input_done = 1'b1; cdf_valid = 1'b1; cdf_min_in = 20'd7; cdf_done = 1'b1; output_done = 1'b1;
    repeat (2) tick();
    input_done = 1'b0; cdf_valid = 1'b0; cdf_done = 1'b0; output_done = 1'b0;
    tick();
    n_cmp++; if ({busy, done, input_start, cdf_start, output_start} !== 5'b0) begin
      n_err++; $display("FAIL ignore_ctrl: got %b want 00000", {busy, done, input_start, cdf_start, output_start}); end
    n_cmp++; if (divisor !== 20'd261144 || cdf_min_out !== 20'd1000) begin
      n_err++; $display("FAIL ignore_latch: got div=%0d min=%0d want 261144/1000", divisor, cdf_min_out); end
  endtask

`ifdef HEQ_OVERLAP_EN
  task automatic test_overlap();
    bit to;
    int e, o;
    min_plan = '{1000, 20000, 3};
    run_frames(3, 4, 3, 8, 1'b0, to);
    n_cmp++; if (to || done_cnt != 1) begin n_err++; $display("FAIL ovl_done_once: got %0d want 1", done_cnt); end
    n_cmp++; if (in_start_cyc.size() != 3) begin n_err++; $display("FAIL ovl_inputs: got %0d want 3", in_start_cyc.size()); end
    if (in_start_cyc.size() == 3 && out_done_cyc.size() > 0) begin
      n_cmp++; if (in_start_cyc[1] >= out_done_cyc[0]) begin
        n_err++; $display("FAIL ovl_overlap: got istart1=%0d want < %0d", in_start_cyc[1], out_done_cyc[0]); end
      n_cmp++; if (in_start_cyc[2] != out_done_cyc[0] + 1) begin
        n_err++; $display("FAIL ovl_realloc: got %0d want %0d", in_start_cyc[2], out_done_cyc[0] + 1); end
    end
    for (int k = 0; k < 3; k++) begin
      if (k < in_ofs_obs.size() && k < out_ofs_obs.size() && k < cdf_ofs_obs.size()) begin
        n_cmp++; if (in_ofs_obs[k] != k % 2 || cdf_ofs_obs[k] != k % 2 || out_ofs_obs[k] != k % 2) begin
          n_err++; $display("FAIL ovl_ofs%0d: got %0d/%0d/%0d want %0d", k, in_ofs_obs[k], cdf_ofs_obs[k], out_ofs_obs[k], k % 2); end
      end
    end
    while (exp_div.size() > 0 && obs_div.size() > 0) begin
      e = exp_div.pop_front(); o = obs_div.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL ovl_sb_div: got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_same_cycle();
    bit to;
    int e, o;
    min_plan = '{100, 2000, 50000};
    run_frames(3, 10, 3, 4, 1'b0, to);
    n_cmp++; if (coincide < 1) begin n_err++; $display("FAIL same_cycle_hit: got %0d want >=1", coincide); end
    n_cmp++; if (to || done_cnt != 1 || obs_div.size() != 3) begin
      n_err++; $display("FAIL same_cycle_frames: got %0d frames done=%0d want 3/1", obs_div.size(), done_cnt); end
    while (exp_div.size() > 0 && obs_div.size() > 0) begin
      e = exp_div.pop_front(); o = obs_div.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL same_cycle_sb_div: got %0d want %0d", o, e); end
    end
  endtask
`else
  task automatic test_serial();
    bit to;
    int nz;
    min_plan = '{1000, 20000, 3};
    run_frames(3, 4, 3, 5, 1'b0, to);
    n_cmp++; if (to || done_cnt != 1) begin n_err++; $display("FAIL ser_done_once: got %0d want 1", done_cnt); end
    n_cmp++; if (in_start_cyc.size() != 3 || out_done_cyc.size() != 3) begin
      n_err++; $display("FAIL ser_frames: got %0d/%0d want 3/3", in_start_cyc.size(), out_done_cyc.size()); end
    for (int k = 1; k < 3; k++) begin
      if (k < in_start_cyc.size() && k <= out_done_cyc.size()) begin
        n_cmp++; if (in_start_cyc[k] != out_done_cyc[k-1] + 1) begin
          n_err++; $display("FAIL ser_gap%0d: got %0d want %0d", k, in_start_cyc[k], out_done_cyc[k-1] + 1); end
      end
    end
    nz = 0;
    foreach (in_ofs_obs[k])  nz += in_ofs_obs[k];
    foreach (cdf_ofs_obs[k]) nz += cdf_ofs_obs[k];
    foreach (out_ofs_obs[k]) nz += out_ofs_obs[k];
    n_cmp++; if (nz != 0) begin n_err++; $display("FAIL ser_offsets: got sum %0d want 0", nz); end
  endtask
`endif

  task automatic test_flat();
    bit to;
    int e, o;
    min_plan = '{262143};
    run_frames(1, 3, 2, 3, 1'b0, to);
    n_cmp++; if (to || obs_div.size() != 1 || obs_div[0] != 1) begin
      n_err++; $display("FAIL flat_edge_div: got %0d entries want divisor 1", obs_div.size()); end
    n_cmp++; if (flat_frame !== 1'b0) begin n_err++; $display("FAIL flat_edge_flag: got %b want 0", flat_frame); end
    min_plan = '{262144, 300000};
    run_frames(2, 3, 2, 3, 1'b0, to);
    n_cmp++; if (to || obs_div.size() != 2) begin n_err++; $display("FAIL flat_frames: got %0d want 2", obs_div.size()); end
    while (exp_div.size() > 0 && obs_div.size() > 0) begin
      e = exp_div.pop_front(); o = obs_div.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL flat_sb_div: got %0d want %0d", o, e); end
      e = exp_min.pop_front(); o = obs_min.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL flat_sb_min: got %0d want %0d", o, e); end
    end
    n_cmp++; if (flat_frame !== 1'b1) begin n_err++; $display("FAIL flat_flag: got %b want 1", flat_frame); end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    min_plan = '{1000, 1000};
    run_frames(2, 4, 3, 8, 1'b1, to);
    n_cmp++; if (to || output_start !== 1'b1) begin n_err++; $display("FAIL midrst_reach_out: got %b want 1", output_start); end
    reset = 1'b1;
    tick();
    n_cmp++; if (all_outs() !== '0) begin n_err++; $display("FAIL midrst_outs: got %h want 0", all_outs()); end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (all_outs() !== '0) begin n_err++; $display("FAIL midrst_after: got %h want 0", all_outs()); end
    min_plan = '{777};
    run_frames(1, 3, 2, 3, 1'b0, to);
    n_cmp++; if (to || done_cnt != 1 || obs_div.size() != 1 || obs_div[0] != 261367 || in_ofs_obs[0] != 0) begin
      n_err++; $display("FAIL midrst_restart: got done=%0d frames=%0d want 1/1 div 261367", done_cnt, obs_div.size()); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_frames = '0; input_done = 1'b0; cdf_done = 1'b0;
    cdf_valid = 1'b0; cdf_min_in = '0; output_done = 1'b0;
    test_reset();
    test_single();
    test_zero_frames();
    test_ignored();
`ifdef HEQ_OVERLAP_EN
    test_overlap();
`else
    test_serial();
`endif
    test_flat();
`ifdef HEQ_OVERLAP_EN
    test_same_cycle();
`endif
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
